rx_pulse_decoder: RTL and testbench

Four-channel RC receiver front end. It measures the high time of the throttle, pitch, roll and yaw servo pulses and converts each to an 8-bit offset in 0..40 (20 = centre). These offsets drive the throttle, pitch, roll and yaw offset generators directly. Per-channel timeouts force failsafe values when the radio link drops.

---
 rtl/rx_pulse_decoder_if.sv | 27 ++
 rtl/rx_pulse_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_rx_pulse_decoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rx_pulse_decoder_if.sv
// rx_pulse_decoder_if: bundles the receiver pins and the decoded channel outputs.
//   rx_pwm          : raw receiver pins [0] throttle, [1] pitch, [2] roll, [3] yaw
//   *_offset        : decoded 8-bit offsets 0..40
//   link_ok         : per-channel valid-link flags
//   update          : per-channel one-clk commit strobes
// master = pin driver / offset consumer side, slave = decoder side.
interface rx_pulse_decoder_if;
    logic [3:0] rx_pwm;
    logic [7:0] throttle_offset;
    logic [7:0] pitch_offset;
    logic [7:0] roll_offset;
    logic [7:0] yaw_offset;
    logic [3:0] link_ok;
    logic [3:0] update;

    modport master (
        output rx_pwm,
        input  throttle_offset, pitch_offset, roll_offset, yaw_offset,
        input  link_ok, update
    );

    modport slave (
        input  rx_pwm,
        output throttle_offset, pitch_offset, roll_offset, yaw_offset,
        output link_ok, update
    );
endinterface

// File: rtl/rx_pulse_decoder.sv
// rx_pulse_decoder: four-channel RC servo pulse decoder with per-channel timeout.
// Measures each channel's high time in ticks and maps it to an offset 0..40
// (20 = centre) using only counters; forces failsafe values on link loss.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : rx_pulse_decoder_if.slave (rx_pwm in; offsets, link_ok, update out)
// Optional feature macro: RX_GLITCH_FILTER_EN adds a 3-sample majority filter
// after the synchronizer (rejects 1-clk glitches, +2 clk latency).
module rx_pulse_decoder #(
    parameter int unsigned CLK_DIV   = 50,
    parameter int unsigned MIN_VALID = 800,
    parameter int unsigned MAX_VALID = 2200,
    parameter int unsigned MIN_WIDTH = 1000,
    parameter int unsigned STEP      = 25,
    parameter int unsigned TIMEOUT   = 25000
) (
    input  logic               clk,
    input  logic               rst,
    rx_pulse_decoder_if.slave  bus
);

    localparam int unsigned NCH     = 4;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned WID_W   = $clog2(MAX_VALID + 2);
    localparam int unsigned STP_W   = $clog2(STEP + 1);
    localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned ACC_W   = 6;
    localparam int unsigned OFS_W   = 8;
    localparam int unsigned ACC_MAX = 40;

    typedef enum logic [1:0] {
        ST_ARM,
        ST_LOW,
        ST_HIGH
    } state_e;

    function automatic logic [OFS_W-1:0] failsafe(input int ch);
        return (ch == 0) ? OFS_W'(0) : OFS_W'(20);
    endfunction

    // Prescaler
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_c;

    always_comb begin
        tick_c = (div_q == DIV_W'(CLK_DIV - 1));
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);
    end

    // Input path: 2-flop sync, optional majority filter, registered edge detect
    logic [NCH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NCH-1:0] prev_q, prev_d, rise_q, rise_d, fall_q, fall_d;
    logic [NCH-1:0] lvl_c;

`ifdef RX_GLITCH_FILTER_EN
    logic [NCH-1:0] hist1_q, hist1_d, hist2_q, hist2_d, filt_q, filt_d;

    always_comb begin
        hist1_d = sync2_q;
        hist2_d = hist1_q;
        filt_d  = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
    end

    // History resets high for the same reason as the synchronizer below
    always_ff @(posedge clk) begin
        if (rst) begin
            hist1_q <= '1;
            hist2_q <= '1;
            filt_q  <= '1;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
            filt_q  <= filt_d;
        end
    end

    assign lvl_c = filt_q;
`else
    assign lvl_c = sync2_q;
`endif

    always_comb begin
        sync1_d = bus.rx_pwm;
        sync2_d = sync1_q;
        prev_d  = lvl_c;
        rise_d  = lvl_c & ~prev_q;
        fall_d  = ~lvl_c & prev_q;
    end

    // Pipeline resets to "high" so a pin already high at reset release never
    // looks like a rising edge and ARM only leaves once a real low is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            div_q   <= div_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Per-channel state
    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [WID_W-1:0] width_q [NCH];
    logic [WID_W-1:0] width_d [NCH];
    logic [STP_W-1:0] step_q  [NCH];
    logic [STP_W-1:0] step_d  [NCH];
    logic [ACC_W-1:0] acc_q   [NCH];
    logic [ACC_W-1:0] acc_d   [NCH];
    logic [TO_W-1:0]  to_q    [NCH];
    logic [TO_W-1:0]  to_d    [NCH];
    logic [OFS_W-1:0] ofs_q   [NCH];
    logic [OFS_W-1:0] ofs_d   [NCH];
    logic [NCH-1:0]   link_q, link_d, upd_q, upd_d, commit_c;

    // Next-state: pulse measurement FSM, mapping counters, commit and timeout
    always_comb begin
        link_d   = link_q;
        upd_d    = '0;
        commit_c = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            width_d[i] = width_q[i];
            step_d[i]  = step_q[i];
            acc_d[i]   = acc_q[i];
            to_d[i]    = to_q[i];
            ofs_d[i]   = ofs_q[i];

            case (state_q[i])
                ST_ARM: begin
                    if (!prev_q[i]) state_d[i] = ST_LOW;
                end
                ST_LOW: begin
                    // The rise cycle's tick is the first tick of the pulse
                    if (rise_q[i]) begin
                        state_d[i] = ST_HIGH;
                        width_d[i] = tick_c ? WID_W'(1) : '0;
                        step_d[i]  = '0;
                        acc_d[i]   = '0;
                    end
                end
                ST_HIGH: begin
                    if (fall_q[i]) begin
                        state_d[i] = ST_LOW;
                        if (width_q[i] >= WID_W'(MIN_VALID) &&
                            width_q[i] <= WID_W'(MAX_VALID)) begin
                            commit_c[i] = 1'b1;
                        end
                    end else if (width_q[i] == WID_W'(MAX_VALID + 1)) begin
                        state_d[i] = ST_ARM;
                    end else if (tick_c) begin
                        width_d[i] = width_q[i] + WID_W'(1);
                        // One acc unit per STEP ticks spent at or above MIN_WIDTH
                        if (width_q[i] >= WID_W'(MIN_WIDTH) &&
                            acc_q[i] != ACC_W'(ACC_MAX)) begin
                            if (step_q[i] == STP_W'(STEP - 1)) begin
                                step_d[i] = '0;
                                acc_d[i]  = acc_q[i] + ACC_W'(1);
                            end else begin
                                step_d[i] = step_q[i] + STP_W'(1);
                            end
                        end
                    end
                end
                default: state_d[i] = ST_ARM;
            endcase

            // Commit takes priority over a coincident timeout expiry
            if (commit_c[i]) begin
                ofs_d[i]  = OFS_W'(acc_q[i]);
                link_d[i] = 1'b1;
                to_d[i]   = '0;
            end else if (tick_c && to_q[i] != TO_W'(TIMEOUT)) begin
                to_d[i] = to_q[i] + TO_W'(1);
                if (to_q[i] == TO_W'(TIMEOUT - 1)) begin
                    ofs_d[i]  = failsafe(i);
                    link_d[i] = 1'b0;
                end
            end
            upd_d[i] = commit_c[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_ARM;
                width_q[i] <= '0;
                step_q[i]  <= '0;
                acc_q[i]   <= '0;
                to_q[i]    <= '0;
                ofs_q[i]   <= failsafe(i);
            end
            link_q <= '0;
            upd_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                width_q[i] <= width_d[i];
                step_q[i]  <= step_d[i];
                acc_q[i]   <= acc_d[i];
                to_q[i]    <= to_d[i];
                ofs_q[i]   <= ofs_d[i];
            end
            link_q <= link_d;
            upd_q  <= upd_d;
        end
    end

    assign bus.throttle_offset = ofs_q[0];
    assign bus.pitch_offset    = ofs_q[1];
    assign bus.roll_offset     = ofs_q[2];
    assign bus.yaw_offset      = ofs_q[3];
    assign bus.link_ok         = link_q;
    assign bus.update          = upd_q;

endmodule

// File: tb/tb_rx_pulse_decoder.sv
// tb_rx_pulse_decoder: directed, table-driven bench for rx_pulse_decoder
// with CLK_DIV=1 (one tick per clk) and default timing otherwise.
module tb_rx_pulse_decoder;

`ifdef RX_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    typedef struct {
        int ch;
        int width;
        int exp_ofs;
        bit exp_commit;
        bit exp_link;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pins = 4'b0000;
    logic [3:0] upd_seen;
    int         checks = 0;
    int         failures = 0;
    vec_t       vecs [14];

    rx_pulse_decoder_if rx_bus ();
    assign rx_bus.rx_pwm = pins;

    rx_pulse_decoder #(.CLK_DIV(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rx_bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        upd_seen = upd_seen | rx_bus.update;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ofs_of(input int ch);
        case (ch)
            0:       return rx_bus.throttle_offset;
            1:       return rx_bus.pitch_offset;
            2:       return rx_bus.roll_offset;
            default: return rx_bus.yaw_offset;
        endcase
    endfunction

    task automatic pulse(input int ch, input int n);
        pins[ch] = 1'b1;
        repeat (n) step();
        pins[ch] = 1'b0;
    endtask

    // Pulse, then check the exact commit cycle, strobe width, offset and link
    task automatic apply_vec(input string tag, input vec_t v);
        logic [31:0] exp_upd;
        exp_upd  = v.exp_commit ? (32'(1) << v.ch) : 32'(0);
        upd_seen = 4'b0000;
        pulse(v.ch, v.width);
        repeat (LAT - 1) step();
        check({tag, "_early_update"}, 32'(upd_seen), 0);
        step();
        check({tag, "_update_at_lat"}, 32'(rx_bus.update), exp_upd);
        step();
        check({tag, "_update_one_clk"}, 32'(rx_bus.update), 0);
        repeat (8) step();
        check({tag, "_offset"}, 32'(ofs_of(v.ch)), 32'(v.exp_ofs));
        check({tag, "_link"}, 32'(rx_bus.link_ok[v.ch]), 32'(v.exp_link));
    endtask

    initial begin
        int k;
        vecs[0]  = '{ch: 1, width: 1500, exp_ofs: 20, exp_commit: 1, exp_link: 1};
        vecs[1]  = '{ch: 0, width: 1000, exp_ofs: 0,  exp_commit: 1, exp_link: 1};
        vecs[2]  = '{ch: 0, width: 1499, exp_ofs: 19, exp_commit: 1, exp_link: 1};
        vecs[3]  = '{ch: 0, width: 2000, exp_ofs: 40, exp_commit: 1, exp_link: 1};
        vecs[4]  = '{ch: 0, width: 2150, exp_ofs: 40, exp_commit: 1, exp_link: 1};
        vecs[5]  = '{ch: 0, width: 2200, exp_ofs: 40, exp_commit: 1, exp_link: 1};
        vecs[6]  = '{ch: 0, width: 799,  exp_ofs: 40, exp_commit: 0, exp_link: 1};
        vecs[7]  = '{ch: 0, width: 800,  exp_ofs: 0,  exp_commit: 1, exp_link: 1};
        vecs[8]  = '{ch: 2, width: 700,  exp_ofs: 20, exp_commit: 0, exp_link: 0};
        vecs[9]  = '{ch: 2, width: 2300, exp_ofs: 20, exp_commit: 0, exp_link: 0};
        vecs[10] = '{ch: 2, width: 1250, exp_ofs: 10, exp_commit: 1, exp_link: 1};
        vecs[11] = '{ch: 2, width: 1024, exp_ofs: 0,  exp_commit: 1, exp_link: 1};
        vecs[12] = '{ch: 2, width: 1025, exp_ofs: 1,  exp_commit: 1, exp_link: 1};
        vecs[13] = '{ch: 2, width: 2201, exp_ofs: 1,  exp_commit: 0, exp_link: 1};

        // Reset with pins low
        upd_seen = 4'b0000;
        repeat (3) step();
        rst = 1'b0;
        check("rst_throttle", 32'(rx_bus.throttle_offset), 0);
        check("rst_pitch", 32'(rx_bus.pitch_offset), 20);
        check("rst_roll", 32'(rx_bus.roll_offset), 20);
        check("rst_yaw", 32'(rx_bus.yaw_offset), 20);
        check("rst_link", 32'(rx_bus.link_ok), 0);
        check("rst_update", 32'(rx_bus.update), 0);
        repeat (6) step();

        for (int i = 0; i < 14; i++) begin
            apply_vec($sformatf("v%0d", i), vecs[i]);
            repeat (4) step();
        end

        // Yaw commit 35, then silence until timeout
        upd_seen = 4'b0000;
        pulse(3, 1880);
        k = 0;
        while (!rx_bus.update[3] && k < 20) begin
            step();
            k++;
        end
        check("yaw_commit_seen", 32'(rx_bus.update[3]), 1);
        check("yaw_offset_35", 32'(rx_bus.yaw_offset), 35);
        repeat (24999) step();
        check("yaw_before_timeout", 32'(rx_bus.yaw_offset), 35);
        check("yaw_link_before_timeout", 32'(rx_bus.link_ok[3]), 1);
        step();
        check("yaw_timeout_failsafe", 32'(rx_bus.yaw_offset), 20);
        check("yaw_timeout_link", 32'(rx_bus.link_ok[3]), 0);
        check("all_link_expired", 32'(rx_bus.link_ok), 0);
        check("throttle_failsafe", 32'(rx_bus.throttle_offset), 0);
        check("pitch_failsafe", 32'(rx_bus.pitch_offset), 20);
        check("roll_failsafe", 32'(rx_bus.roll_offset), 20);

        // Pitch pin high across reset release: that pulse must be ignored
        rst  = 1'b1;
        pins = 4'b0010;
        repeat (3) step();
        rst = 1'b0;
        upd_seen = 4'b0000;
        repeat (300) step();
        pins[1] = 1'b0;
        repeat (10) step();
        check("arm_no_update", 32'(upd_seen), 0);
        check("arm_pitch_unchanged", 32'(rx_bus.pitch_offset), 20);
        apply_vec("arm_next", '{ch: 1, width: 1600, exp_ofs: 24, exp_commit: 1, exp_link: 1});

        // Reset asserted mid-pulse discards the pulse
        upd_seen = 4'b0000;
        pins[1] = 1'b1;
        repeat (500) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (500) step();
        pins[1] = 1'b0;
        repeat (10) step();
        check("midrst_no_update", 32'(upd_seen), 0);
        check("midrst_pitch", 32'(rx_bus.pitch_offset), 20);
        check("midrst_link", 32'(rx_bus.link_ok[1]), 0);
        apply_vec("midrst_rearm", '{ch: 1, width: 1500, exp_ofs: 20, exp_commit: 1, exp_link: 1});

        // One-clk glitch on throttle while idle
        upd_seen = 4'b0000;
        pins[0] = 1'b1;
        step();
        pins[0] = 1'b0;
        repeat (20) step();
        check("glitch_no_update", 32'(upd_seen), 0);
        check("glitch_throttle", 32'(rx_bus.throttle_offset), 0);
        check("glitch_link", 32'(rx_bus.link_ok[0]), 0);
        apply_vec("post_glitch", '{ch: 0, width: 1100, exp_ofs: 4, exp_commit: 1, exp_link: 1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
